// File: rtl/ctrl_issue_sched.sv
// Round-robin opcode arbiter feeding an external control decoder; registers and issues the control word
// over valid/ready, stalling for multi-cycle ops. CTRL_SCHED_BYPASS_EN removes the DECODE cycle.
module ctrl_issue_sched #(
  parameter int OPW = 7,
  parameter int CW  = 26
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_req0_valid,
  input  logic [OPW-1:0] i_req0_op,
  output logic           o_req0_ready,
  input  logic           i_req1_valid,
  input  logic [OPW-1:0] i_req1_op,
  output logic           o_req1_ready,
  output logic [OPW-1:0] o_dec_op,
  input  logic [CW-1:0]  i_dec_word,
  output logic           o_cw_valid,
  output logic [CW-1:0]  o_cw_data,
  input  logic           i_cw_ready,
  output logic           o_grant_id,
  output logic           o_busy
);
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ISSUE, S_HOLD} state_t;

`ifdef CTRL_SCHED_BYPASS_EN
  localparam state_t GRANT_NXT = S_ISSUE;
`else
  localparam state_t GRANT_NXT = S_DECODE;
`endif

  state_t         r_state;
  state_t         w_state_nxt;
  logic [OPW-1:0] r_op_q;
  logic [CW-1:0]  r_cw_data;
  logic           r_grant_id;
  logic           r_last_grant;
  logic [1:0]     r_cnt;
  logic           w_idle;
  logic           w_sel;
  logic           w_grant;
  logic           w_accept;
  logic [OPW-1:0] w_sel_op;

  // Ready is gated by reset so nothing is granted while reset is held.
  assign w_idle   = (r_state == S_IDLE) && i_rst_n;
  assign w_sel    = (i_req0_valid && i_req1_valid) ? ~r_last_grant : i_req1_valid;
  assign w_sel_op = w_sel ? i_req1_op : i_req0_op;
  assign w_grant  = w_idle && (i_req0_valid || i_req1_valid);
  assign w_accept = (r_state == S_ISSUE) && i_cw_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant) w_state_nxt = GRANT_NXT;
      S_DECODE: w_state_nxt = S_ISSUE;
      S_ISSUE:  if (i_cw_ready) w_state_nxt = r_op_q[OPW-1] ? S_HOLD : S_IDLE;
      S_HOLD:   if (r_cnt == 2'd0) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_req0_ready = w_grant && !w_sel;
    o_req1_ready = w_grant && w_sel;
    o_cw_valid   = (r_state == S_ISSUE);
    o_busy       = (r_state != S_IDLE);
    o_dec_op     = r_op_q;
`ifdef CTRL_SCHED_BYPASS_EN
    if (w_grant) o_dec_op = w_sel_op;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_q       <= '0;
      r_cw_data    <= '0;
      r_grant_id   <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= 2'd0;
    end else begin
      if (w_grant) begin
        r_op_q       <= w_sel_op;
        r_grant_id   <= w_sel;
        r_last_grant <= w_sel;
      end
`ifdef CTRL_SCHED_BYPASS_EN
      if (w_grant) r_cw_data <= i_dec_word;
`else
      if (r_state == S_DECODE) r_cw_data <= i_dec_word;
`endif
      // Counter loads the hold field on acceptance and stops at zero.
      if (w_accept && r_op_q[OPW-1]) r_cnt <= r_op_q[OPW-2 -: 2];
      else if (r_state == S_HOLD && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
    end
  end

  assign o_cw_data  = r_cw_data;
  assign o_grant_id = r_grant_id;
endmodule
